mem_refill_arbiter: RTL and testbench



---
 rtl/mem_refill_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_refill_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter
//
// Shares one memory refill channel between the L1 I-cache and L1 D-cache
// miss paths. Each cache owns a one-deep request slot (IDLE/PEND/ISSUED/WAIT).
// A single output register carries the granted request to memory and is held
// until memory accepts it. Responses are steered back to the owning cache by
// source ID and registered into the per-cache data outputs.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   ic2memReqAddr_i/ic2memReqValid_i I-cache miss request (single-cycle pulse)
//   dc2memReqAddr_i/dc2memReqValid_i D-cache miss request (single-cycle pulse)
//   memReqAddr_o/Src_o/Valid_o       request to memory (0 = IC, 1 = DC)
//   memReqReady_i                    memory accepts the request this cycle
//   memRespData_i/Src_i/Valid_i      returned line from memory
//   mem2icData_o/mem2icRespValid_o   line + one-cycle pulse to the I-cache
//   mem2dcData_o/mem2dcRespValid_o   line + one-cycle pulse to the D-cache
//   icBusy_o/dcBusy_o                slot not IDLE
//   reqOverrun_o                     sticky: request while its slot was busy
//   respError_o                      sticky: response for a slot not in WAIT
module mem_refill_arbiter #(
    parameter int ADDR_BITS = 26,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] ic2memReqAddr_i,
    input  logic                 ic2memReqValid_i,
    input  logic [ADDR_BITS-1:0] dc2memReqAddr_i,
    input  logic                 dc2memReqValid_i,
    output logic [ADDR_BITS-1:0] memReqAddr_o,
    output logic                 memReqSrc_o,
    output logic                 memReqValid_o,
    input  logic                 memReqReady_i,
    input  logic [LINE_BITS-1:0] memRespData_i,
    input  logic                 memRespSrc_i,
    input  logic                 memRespValid_i,
    output logic [LINE_BITS-1:0] mem2icData_o,
    output logic                 mem2icRespValid_o,
    output logic [LINE_BITS-1:0] mem2dcData_o,
    output logic                 mem2dcRespValid_o,
    output logic                 icBusy_o,
    output logic                 dcBusy_o,
    output logic                 reqOverrun_o,
    output logic                 respError_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PEND   = 2'd1;
    localparam logic [1:0] S_ISSUED = 2'd2;
    localparam logic [1:0] S_WAIT   = 2'd3;

    // Slot index 0 is the I-cache, index 1 the D-cache (matches source IDs).
    logic [1:0]           slot_q      [2];
    logic [1:0]           slot_d      [2];
    logic [ADDR_BITS-1:0] slot_addr_q [2];
    logic [ADDR_BITS-1:0] slot_addr_d [2];

    logic                 req_vld_q, req_vld_d;
    logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
    logic                 req_src_q, req_src_d;
    logic                 last_grant_q, last_grant_d;

    logic                 ic_resp_vld_q, ic_resp_vld_d;
    logic                 dc_resp_vld_q, dc_resp_vld_d;
    logic [LINE_BITS-1:0] ic_data_q, ic_data_d;
    logic [LINE_BITS-1:0] dc_data_q, dc_data_d;
    logic                 overrun_q, overrun_d;
    logic                 resp_err_q, resp_err_d;

    logic [1:0]           in_vld;
    logic [ADDR_BITS-1:0] in_addr [2];
    logic [1:0]           resp_hit;
    logic [1:0]           cand;
    logic [1:0]           grant;
    logic                 handshake;
    logic                 grant_any;
    logic                 grant_src;
    logic [ADDR_BITS-1:0] grant_addr;

    assign in_vld     = {dc2memReqValid_i, ic2memReqValid_i};
    assign in_addr[0] = ic2memReqAddr_i;
    assign in_addr[1] = dc2memReqAddr_i;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                slot_q[s]      <= S_IDLE;
                slot_addr_q[s] <= '0;
            end
            req_vld_q     <= 1'b0;
            req_addr_q    <= '0;
            req_src_q     <= 1'b0;
            last_grant_q  <= 1'b1;  // DC, so IC wins the first tie
            ic_resp_vld_q <= 1'b0;
            dc_resp_vld_q <= 1'b0;
            ic_data_q     <= '0;
            dc_data_q     <= '0;
            overrun_q     <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            slot_addr_q   <= slot_addr_d;
            req_vld_q     <= req_vld_d;
            req_addr_q    <= req_addr_d;
            req_src_q     <= req_src_d;
            last_grant_q  <= last_grant_d;
            ic_resp_vld_q <= ic_resp_vld_d;
            dc_resp_vld_q <= dc_resp_vld_d;
            ic_data_q     <= ic_data_d;
            dc_data_q     <= dc_data_d;
            overrun_q     <= overrun_d;
            resp_err_q    <= resp_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        slot_d        = slot_q;
        slot_addr_d   = slot_addr_q;
        req_vld_d     = req_vld_q;
        req_addr_d    = req_addr_q;
        req_src_d     = req_src_q;
        last_grant_d  = last_grant_q;
        overrun_d     = overrun_q;
        resp_err_d    = resp_err_q;
        grant         = 2'b00;

        handshake = req_vld_q & memReqReady_i;

        for (int s = 0; s < 2; s++) begin
            resp_hit[s] = memRespValid_i && (memRespSrc_i == 1'(s)) && (slot_q[s] == S_WAIT);
            // An IDLE slot with a pulse this cycle may bypass PEND. A WAIT slot
            // being refilled in the same cycle is not IDLE, so it cannot.
            cand[s] = (slot_q[s] == S_PEND) || ((slot_q[s] == S_IDLE) && in_vld[s]);
        end

        // The register is loaded only when it was empty at this edge, so a
        // handshake and a grant never land in the same cycle.
        grant_any  = !req_vld_q && (cand != 2'b00);
        grant_src  = (cand == 2'b11) ? ~last_grant_q : cand[1];
        grant_addr = (slot_q[grant_src] == S_IDLE) ? in_addr[grant_src] : slot_addr_q[grant_src];
        if (grant_any) begin
            grant[grant_src] = 1'b1;
        end

        for (int s = 0; s < 2; s++) begin
            case (slot_q[s])
                S_IDLE: begin
                    if (in_vld[s]) begin
                        slot_addr_d[s] = in_addr[s];
                        slot_d[s]      = grant[s] ? S_ISSUED : S_PEND;
                    end
                end
                S_PEND: begin
                    if (grant[s]) begin
                        slot_d[s] = S_ISSUED;
                    end
                end
                S_ISSUED: begin
                    if (handshake && (req_src_q == 1'(s))) begin
                        slot_d[s] = S_WAIT;
                    end
                end
                default: begin  // S_WAIT
                    if (resp_hit[s]) begin
                        if (in_vld[s]) begin
                            slot_addr_d[s] = in_addr[s];
                            slot_d[s]      = S_PEND;
                        end else begin
                            slot_d[s] = S_IDLE;
                        end
                    end
                end
            endcase

            if (in_vld[s] && !((slot_q[s] == S_IDLE) || resp_hit[s])) begin
                overrun_d = 1'b1;
            end
        end

        if (memRespValid_i && (slot_q[memRespSrc_i] != S_WAIT)) begin
            resp_err_d = 1'b1;
        end

        if (handshake) begin
            req_vld_d = 1'b0;
        end
        if (grant_any) begin
            req_vld_d    = 1'b1;
            req_addr_d   = grant_addr;
            req_src_d    = grant_src;
            last_grant_d = grant_src;
        end

        ic_resp_vld_d = resp_hit[0];
        dc_resp_vld_d = resp_hit[1];
        ic_data_d     = resp_hit[0] ? memRespData_i : ic_data_q;
        dc_data_d     = resp_hit[1] ? memRespData_i : dc_data_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        memReqValid_o     = req_vld_q;
        memReqAddr_o      = req_addr_q;
        memReqSrc_o       = req_src_q;
        mem2icRespValid_o = ic_resp_vld_q;
        mem2dcRespValid_o = dc_resp_vld_q;
        mem2icData_o      = ic_data_q;
        mem2dcData_o      = dc_data_q;
        icBusy_o          = (slot_q[0] != S_IDLE);
        dcBusy_o          = (slot_q[1] != S_IDLE);
        reqOverrun_o      = overrun_q;
        respError_o       = resp_err_q;
    end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Testbench for mem_refill_arbiter: a cycle table of directed scenarios,
// a hand-written backpressure/overrun sequence, and a randomized run checked
// against a transaction-level model of the two cache requesters.
module tb_mem_refill_arbiter;

    localparam int AW = 26;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ic2memReqAddr_i, dc2memReqAddr_i, memReqAddr_o;
    logic          ic2memReqValid_i, dc2memReqValid_i;
    logic          memReqSrc_o, memReqValid_o, memReqReady_i;
    logic [LW-1:0] memRespData_i, mem2icData_o, mem2dcData_o;
    logic          memRespSrc_i, memRespValid_i;
    logic          mem2icRespValid_o, mem2dcRespValid_o;
    logic          icBusy_o, dcBusy_o, reqOverrun_o, respError_o;

    always #5 clk = ~clk;

    mem_refill_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW)) dut (
        .clk(clk), .reset(reset),
        .ic2memReqAddr_i(ic2memReqAddr_i), .ic2memReqValid_i(ic2memReqValid_i),
        .dc2memReqAddr_i(dc2memReqAddr_i), .dc2memReqValid_i(dc2memReqValid_i),
        .memReqAddr_o(memReqAddr_o), .memReqSrc_o(memReqSrc_o),
        .memReqValid_o(memReqValid_o), .memReqReady_i(memReqReady_i),
        .memRespData_i(memRespData_i), .memRespSrc_i(memRespSrc_i),
        .memRespValid_i(memRespValid_i),
        .mem2icData_o(mem2icData_o), .mem2icRespValid_o(mem2icRespValid_o),
        .mem2dcData_o(mem2dcData_o), .mem2dcRespValid_o(mem2dcRespValid_o),
        .icBusy_o(icBusy_o), .dcBusy_o(dcBusy_o),
        .reqOverrun_o(reqOverrun_o), .respError_o(respError_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          rst, icv, dcv, rdy, rv, rs;
        logic [AW-1:0] ica, dca;
        logic [7:0]    rb;
        logic          ev, es, eicv, edcv, eicb, edcb, eovr, eerr;
        logic [AW-1:0] ea;
        logic [7:0]    eicd, edcd;
    } vec_t;

    function automatic vec_t mk(input int rst, icv, ica, dcv, dca, rdy, rv, rs, rb,
                                input int ev, ea, es, eicv, edcv, eicd, edcd,
                                input int eicb, edcb, eovr, eerr);
        vec_t v;
        v.rst = 1'(rst); v.icv = 1'(icv); v.ica = AW'(ica); v.dcv = 1'(dcv); v.dca = AW'(dca);
        v.rdy = 1'(rdy); v.rv = 1'(rv); v.rs = 1'(rs); v.rb = 8'(rb);
        v.ev = 1'(ev); v.ea = AW'(ea); v.es = 1'(es); v.eicv = 1'(eicv); v.edcv = 1'(edcv);
        v.eicd = 8'(eicd); v.edcd = 8'(edcd); v.eicb = 1'(eicb); v.edcb = 1'(edcb);
        v.eovr = 1'(eovr); v.eerr = 1'(eerr);
        return v;
    endfunction

    vec_t tbl[$];

    // Transaction-level model state for the random phase.
    bit            m_open [2];   // request accepted, not yet taken by memory
    bit            m_mem  [2];   // taken by memory, response not yet delivered
    logic [AW-1:0] m_addr [2];
    logic          m_icv, m_dcv, m_ovr, m_err;
    logic [LW-1:0] m_icd, m_dcd;
    int            age [2];
    logic          pv, prdy, ps;
    logic [AW-1:0] pa;

    task automatic drive_idle();
        reset = 1'b0;
        ic2memReqValid_i = 1'b0; ic2memReqAddr_i = '0;
        dc2memReqValid_i = 1'b0; dc2memReqAddr_i = '0;
        memReqReady_i = 1'b1;
        memRespValid_i = 1'b0; memRespSrc_i = 1'b0; memRespData_i = '0;
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_open[s] = 0; m_mem[s] = 0; m_addr[s] = '0; age[s] = 0;
        end
        m_icv = 0; m_dcv = 0; m_ovr = 0; m_err = 0; m_icd = '0; m_dcd = '0;
        pv = 0; prdy = 0; ps = 0; pa = '0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] oa;
        logic          os;

        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // rst icv ica dcv dca rdy rv rs rb | ev ea es icv dcv icd dcd icb dcb ovr err
        // Single IC miss
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h123,0,0,1,0,0,0,   1,'h123,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0,'hA5,    0,0,0,1,0,'hA5,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'hA5,0,0,0,0,0));
        // Tie after reset: IC first, DC two cycles later
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h10,1,'h20,1,0,0,0, 1,'h10,0,0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       1,'h20,1,0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0,'h11,    0,0,0,1,0,'h11,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,1,'h22,    0,0,0,0,1,'h11,'h22,0,0,0,0));
        // Lone IC grant, then a repeat tie goes to DC
        tbl.push_back(mk(0,1,'h30,0,0,1,0,0,0,    1,'h30,0,0,0,'h11,'h22,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h11,'h22,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0,'h33,    0,0,0,1,0,'h33,'h22,0,0,0,0));
        tbl.push_back(mk(0,1,'h40,1,'h50,1,0,0,0, 1,'h50,1,0,0,'h33,'h22,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h33,'h22,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       1,'h40,0,0,0,'h33,'h22,1,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h33,'h22,1,1,0,0));
        // Out-of-order responses: DC before IC
        tbl.push_back(mk(0,0,0,0,0,1,1,1,'h44,    0,0,0,0,1,'h33,'h44,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,0,'h55,    0,0,0,1,0,'h55,'h44,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h55,'h44,0,0,0,0));
        // Backpressure: ready low for 7 cycles
        tbl.push_back(mk(0,0,0,1,'h3FF,0,0,0,0,   1,'h3FF,1,0,0,'h55,'h44,0,1,0,0));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(0,0,0,0,0,0,0,0,0,   1,'h3FF,1,0,0,'h55,'h44,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h55,'h44,0,1,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,1,'h66,    0,0,0,0,1,'h55,'h66,0,0,0,0));
        // Overrun while WAIT, stray DC response
        tbl.push_back(mk(0,1,'h77,0,0,1,0,0,0,    1,'h77,0,0,0,'h55,'h66,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h55,'h66,1,0,0,0));
        tbl.push_back(mk(0,1,'h99,0,0,1,0,0,0,    0,0,0,0,0,'h55,'h66,1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,1,1,'h88,    0,0,0,0,0,'h55,'h66,1,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,1,1,0,'h12,    0,0,0,1,0,'h12,'h66,0,0,1,1));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,'h12,'h66,0,0,1,1));
        // Same-cycle response and request, then reset while ISSUED
        tbl.push_back(mk(1,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h60,0,0,1,0,0,0,    1,'h60,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,1,0,0,0));
        tbl.push_back(mk(0,1,'h55,0,0,1,1,0,'h77, 0,0,0,1,0,'h77,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,       1,'h55,0,0,0,'h77,0,1,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,       1,'h55,0,0,0,'h77,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,       0,0,0,0,0,0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,'h99,    0,0,0,0,0,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,0,0,1,0,0,0,       0,0,0,0,0,0,0,0,0,0,1));

        foreach (tbl[i]) begin
            @(negedge clk);
            reset            = tbl[i].rst;
            ic2memReqValid_i = tbl[i].icv; ic2memReqAddr_i = tbl[i].ica;
            dc2memReqValid_i = tbl[i].dcv; dc2memReqAddr_i = tbl[i].dca;
            memReqReady_i    = tbl[i].rdy;
            memRespValid_i   = tbl[i].rv;  memRespSrc_i = tbl[i].rs;
            memRespData_i    = {32{tbl[i].rb}};
            @(posedge clk);
            #1;
            oa = memReqValid_o ? memReqAddr_o : AW'(0);
            os = memReqValid_o & memReqSrc_o;
            chk($sformatf("vec%0d.req", i), {memReqValid_o, oa, os}, {tbl[i].ev, tbl[i].ea, tbl[i].es});
            chk($sformatf("vec%0d.pulse", i), {mem2icRespValid_o, mem2dcRespValid_o}, {tbl[i].eicv, tbl[i].edcv});
            chk($sformatf("vec%0d.icdata", i), mem2icData_o, {32{tbl[i].eicd}});
            chk($sformatf("vec%0d.dcdata", i), mem2dcData_o, {32{tbl[i].edcd}});
            chk($sformatf("vec%0d.flags", i), {icBusy_o, dcBusy_o, reqOverrun_o, respError_o},
                {tbl[i].eicb, tbl[i].edcb, tbl[i].eovr, tbl[i].eerr});
        end

        // Overrun while PEND under backpressure keeps the first address.
        @(negedge clk); drive_idle(); reset = 1'b1;
        @(negedge clk); drive_idle(); memReqReady_i = 1'b0;
        dc2memReqValid_i = 1'b1; dc2memReqAddr_i = AW'('h0AA);
        @(negedge clk);
        chk("seq.dc_issue", {memReqValid_o, memReqSrc_o, memReqAddr_o}, {1'b1, 1'b1, AW'('h0AA)});
        dc2memReqValid_i = 1'b0;
        ic2memReqValid_i = 1'b1; ic2memReqAddr_i = AW'('h0BB);
        @(negedge clk);
        chk("seq.ic_pend", {icBusy_o, reqOverrun_o, memReqAddr_o}, {1'b1, 1'b0, AW'('h0AA)});
        ic2memReqAddr_i = AW'('h0CC);
        @(negedge clk);
        chk("seq.overrun", reqOverrun_o, 1'b1);
        ic2memReqValid_i = 1'b0; memReqReady_i = 1'b1;
        @(negedge clk);
        chk("seq.handoff_gap", memReqValid_o, 1'b0);
        @(negedge clk);
        chk("seq.ic_issue", {memReqValid_o, memReqSrc_o, memReqAddr_o}, {1'b1, 1'b0, AW'('h0BB)});

        // Randomized run against the transaction-level model.
        @(negedge clk); drive_idle(); reset = 1'b1;
        model_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic          p [2];
            logic [AW-1:0] a [2];
            logic          rdy, rv, rs, hs, hsrc, resp_ok, acc;
            logic [LW-1:0] rd;

            @(negedge clk);
            chk("rnd.pulse", {mem2icRespValid_o, mem2dcRespValid_o}, {m_icv, m_dcv});
            chk("rnd.icdata", mem2icData_o, m_icd);
            chk("rnd.dcdata", mem2dcData_o, m_dcd);
            chk("rnd.busy", {icBusy_o, dcBusy_o}, {m_open[0] | m_mem[0], m_open[1] | m_mem[1]});
            chk("rnd.sticky", {reqOverrun_o, respError_o}, {m_ovr, m_err});
            if (pv && !prdy)
                chk("rnd.hold", {memReqValid_o, memReqSrc_o, memReqAddr_o}, {1'b1, ps, pa});
            if (memReqValid_o)
                chk("rnd.issue", {1'(m_open[memReqSrc_o]), memReqAddr_o}, {1'b1, m_addr[memReqSrc_o]});
            for (int s = 0; s < 2; s++) begin
                age[s] = m_open[s] ? age[s] + 1 : 0;
                if (age[s] > 60) begin
                    chk($sformatf("rnd.starve%0d", s), age[s], 0);
                    age[s] = 0;
                end
            end

            if ($urandom_range(0, 299) == 0) begin
                drive_idle();
                reset = 1'b1;
                model_reset();
                continue;
            end

            for (int s = 0; s < 2; s++) begin
                p[s] = ($urandom_range(0, 3) == 0);
                a[s] = AW'($urandom);
            end
            rdy = ($urandom_range(0, 3) != 0);
            rv = 1'b0; rs = 1'b0;
            if ((m_mem[0] || m_mem[1]) && $urandom_range(0, 2) == 0) begin
                rv = 1'b1;
                rs = (m_mem[0] && m_mem[1]) ? 1'($urandom) : (m_mem[1] ? 1'b1 : 1'b0);
            end else if ($urandom_range(0, 199) == 0) begin
                rv = 1'b1;
                rs = 1'($urandom);
            end
            for (int k = 0; k < 8; k++) rd[k*32 +: 32] = $urandom;

            reset = 1'b0;
            ic2memReqValid_i = p[0]; ic2memReqAddr_i = a[0];
            dc2memReqValid_i = p[1]; dc2memReqAddr_i = a[1];
            memReqReady_i = rdy;
            memRespValid_i = rv; memRespSrc_i = rs; memRespData_i = rd;

            // What memory and the caches observe at the coming edge.
            hs      = memReqValid_o & rdy;
            hsrc    = memReqSrc_o;
            resp_ok = rv && m_mem[rs];
            m_icv   = resp_ok && (rs == 1'b0);
            m_dcv   = resp_ok && (rs == 1'b1);
            if (m_icv) m_icd = rd;
            if (m_dcv) m_dcd = rd;
            if (rv && !resp_ok) m_err = 1'b1;
            if (resp_ok) m_mem[rs] = 0;
            if (hs) begin
                m_open[hsrc] = 0;
                m_mem[hsrc]  = 1;
            end
            for (int s = 0; s < 2; s++) begin
                // A cache may miss again once its previous miss is delivered,
                // including in the delivering cycle itself.
                acc = p[s] && (!(m_open[s] || m_mem[s] || (hs && hsrc == 1'(s)))
                               || (resp_ok && rs == 1'(s)));
                if (p[s] && !acc) m_ovr = 1'b1;
                if (acc) begin
                    m_open[s] = 1;
                    m_addr[s] = a[s];
                end
            end
            pv = memReqValid_o; prdy = rdy; ps = memReqSrc_o; pa = memReqAddr_o;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
